// File: rtl/pill_schedule_tracker_pkg.sv
// Shared types and constants for the pill schedule tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pill_schedule_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DUE   = 2'd2
  } chan_state_t;

  // Largest value that still prints as a single ASCII digit on the LCD.
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // romContent field positions (LSB of each nibble).
  localparam int PATIENT_LSB = 24;
  localparam int ID1_LSB     = 20;
  localparam int DUR1_LSB    = 16;
  localparam int ID2_LSB     = 12;
  localparam int DUR2_LSB    = 8;
  localparam int ID3_LSB     = 4;
  localparam int DUR3_LSB    = 0;

  // Durations above one digit are shown and counted as 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] n);
    return (n > DIGIT_MAX) ? DIGIT_MAX : n;
  endfunction

endpackage

// File: rtl/pill_schedule_tracker_channel.sv
// One pill countdown: IDLE/COUNT/DUE FSM with remaining, grace and miss registers.
// Latency: every output is a register; changes appear the cycle after the causing edge.
// Backpressure: none; unit_tick, taken and start are single-cycle pulses, start wins.
// Optional PILL_EARLY_ACCEPT_EN: a dose taken while counting restarts the interval.
module pill_channel
  import pill_schedule_tracker_pkg::*;
#(
  parameter int GRACE_UNITS = 3,
  parameter int MAX_MISSES  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] duration,
  input  logic       unit_tick,
  input  logic       taken,
  output logic [3:0] remaining,
  output logic       alarm,
  output logic [3:0] miss_count,
  output logic       miss_pulse
);

  chan_state_t state, state_nxt;
  logic [3:0]  dur_q, dur_nxt;
  logic [3:0]  rem_nxt;
  logic [3:0]  grace, grace_nxt;
  logic [3:0]  miss_nxt;
  logic        alarm_nxt;
  logic        pulse_nxt;
  logic        early_take;

`ifdef PILL_EARLY_ACCEPT_EN
  assign early_take = taken;
`else
  assign early_take = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dur_q      <= 4'd0;
      remaining  <= 4'd0;
      grace      <= 4'd0;
      miss_count <= 4'd0;
      alarm      <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      dur_q      <= dur_nxt;
      remaining  <= rem_nxt;
      grace      <= grace_nxt;
      miss_count <= miss_nxt;
      alarm      <= alarm_nxt;
      miss_pulse <= pulse_nxt;
    end
  end

  // Next-state logic: start first, then taken over tick inside each state.
  always_comb begin
    state_nxt = state;
    dur_nxt   = dur_q;
    rem_nxt   = remaining;
    grace_nxt = grace;
    miss_nxt  = miss_count;
    alarm_nxt = alarm;
    pulse_nxt = 1'b0;
    if (start) begin
      dur_nxt   = duration;
      rem_nxt   = duration;
      grace_nxt = 4'd0;
      miss_nxt  = 4'd0;
      alarm_nxt = 1'b0;
      state_nxt = (duration == 4'd0) ? IDLE : COUNT;
    end else begin
      case (state)
        IDLE: begin
          rem_nxt = 4'd0;
        end
        COUNT: begin
          if (early_take) begin
            rem_nxt = dur_q;
          end else if (unit_tick) begin
            rem_nxt = remaining - 4'd1;
            if (remaining == 4'd1) begin
              state_nxt = DUE;
              alarm_nxt = 1'b1;
              grace_nxt = 4'(GRACE_UNITS);
            end
          end
        end
        DUE: begin
          if (taken) begin
            alarm_nxt = 1'b0;
            rem_nxt   = dur_q;
            state_nxt = COUNT;
          end else if (unit_tick) begin
            grace_nxt = grace - 4'd1;
            if (grace == 4'd1) begin
              miss_nxt  = (miss_count < 4'(MAX_MISSES)) ? miss_count + 4'd1 : miss_count;
              pulse_nxt = 1'b1;
              alarm_nxt = 1'b0;
              rem_nxt   = dur_q;
              state_nxt = COUNT;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          rem_nxt   = 4'd0;
          alarm_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pill_schedule_tracker.sv
// Three pill countdowns with alarms and miss counters feeding the LCD controller.
// Latency: outputs registered; one cycle from triggering edge to visible change.
// Backpressure: none; start/pillTaken are one-cycle pulses. Optional macro PILL_EARLY_ACCEPT_EN.
module pill_schedule_tracker
  import pill_schedule_tracker_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 1000,
  parameter int GRACE_UNITS    = 3,
  parameter int MAX_MISSES     = 9
) (
  input  logic        clkOneMilliSecond,
  input  logic        resetn,
  input  logic        start,
  input  logic [27:0] romContent,
  input  logic [2:0]  pillTaken,
  output logic [11:0] pill12And3Duration,
  output logic [27:0] missWord,
  output logic [2:0]  alarm,
  output logic [2:0]  missPulse,
  output logic        running
);

  localparam int CW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_UNIT - 1);

  logic [CW-1:0] presc;
  logic          unit_tick;
  logic [3:0]    dur   [3];
  logic [3:0]    rem   [3];
  logic [3:0]    miss  [3];
  logic          unused_rom_fields;

  // Patient and pill ID nibbles belong to the LCD path, not to scheduling.
  assign unused_rom_fields = ^{romContent[PATIENT_LSB +: 4], romContent[ID1_LSB +: 4],
                               romContent[ID2_LSB +: 4], romContent[ID3_LSB +: 4]};

  assign dur[0] = clamp_digit(romContent[DUR1_LSB +: 4]);
  assign dur[1] = clamp_digit(romContent[DUR2_LSB +: 4]);
  assign dur[2] = clamp_digit(romContent[DUR3_LSB +: 4]);

  // A start cycle never produces a tick; the prescaler restarts from 0.
  assign unit_tick = running && !start && (presc == TICK_LAST);

  // Prescaler and running flag.
  always_ff @(posedge clkOneMilliSecond or negedge resetn) begin
    if (!resetn) begin
      presc   <= '0;
      running <= 1'b0;
    end else if (start) begin
      presc   <= '0;
      running <= 1'b1;
    end else if (running) begin
      presc   <= (presc == TICK_LAST) ? '0 : presc + CW'(1);
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    pill_channel #(
      .GRACE_UNITS (GRACE_UNITS),
      .MAX_MISSES  (MAX_MISSES)
    ) u_chan (
      .clk        (clkOneMilliSecond),
      .rst_n      (resetn),
      .start      (start),
      .duration   (dur[i]),
      .unit_tick  (unit_tick),
      .taken      (pillTaken[i]),
      .remaining  (rem[i]),
      .alarm      (alarm[i]),
      .miss_count (miss[i]),
      .miss_pulse (missPulse[i])
    );
  end

  assign pill12And3Duration = {rem[0], rem[1], rem[2]};
  assign missWord = {8'h00, miss[0], 4'h0, miss[1], 4'h0, miss[2]};

endmodule
